biu_ram_responder: RTL and testbench

Single-transfer BIU target (responder) backed by an internal RAM: accepts address phases on the BIU request channel, performs the access, and returns in-order `ack`/`err` plus read data after a fixed latency. It sits at the far end of the BIU from a data-side initiator. It serves as the on-chip data scratchpad and as the reference target in unit and core benches. It throttles acceptance by a maximum-outstanding limit so that initiator inflight/discard logic can be exercised.

---
 rtl/biu_constants_pkg.sv | 46 ++++
 rtl/biu_ram_responder_array.sv | 42 ++++
 rtl/biu_ram_responder.sv | 147 ++++++++++++++
 tb/tb_biu_ram_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/biu_constants_pkg.sv
// rtl/biu_constants_pkg.sv - shared BIU transfer types, constants and byte-enable helper
//
// Purpose : common definitions for BIU initiators and responders.
// Contents: biu_size_t, biu_type_t, biu_prot_t, protection constants,
//           biu_be(size, adr) byte-enable helper.
package biu_constants_pkg;

   typedef enum logic [2:0] {
      BYTE  = 3'd0,
      HWORD = 3'd1,
      WORD  = 3'd2,
      DWORD = 3'd3,
      QWORD = 3'd4
   } biu_size_t;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } biu_type_t;

   typedef logic [2:0] biu_prot_t;

   localparam biu_prot_t PROT_DATA       = 3'b001;
   localparam biu_prot_t PROT_PRIVILEGED = 3'b010;
   localparam biu_prot_t PROT_CACHEABLE  = 3'b100;

   // Byte enables for a transfer; adr is the byte lane within the bus word
   // (callers on a 32-bit bus pass adr[2] as 0). Bits above XLEN/8 are zero
   // for any aligned transfer that fits the bus, so callers truncate.
   function automatic logic [7:0] biu_be(input biu_size_t size, input logic [2:0] adr);
      case (size)
         BYTE   : return 8'h01 << adr;
         HWORD  : return 8'h03 << adr;
         WORD   : return 8'h0f << adr;
         DWORD  : return 8'hff;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/biu_ram_responder_array.sv
// rtl/biu_ram_responder_array.sv - single-port byte-enable synchronous RAM, write-first
//
// Purpose : storage behind biu_ram_responder; no reset on contents or output.
// Ports   : clk  - clock
//           en   - access enable (read or write this edge)
//           we   - write when en
//           be   - byte enables for a write
//           adr  - word index
//           d    - write data
//           q    - read data, registered; on a write returns the merged new word
module biu_ram_array #(
   parameter int XLEN  = 32,
   parameter int WORDS = 1024,
   parameter int IW    = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [XLEN/8-1:0] be,
   input  logic [IW-1:0]     adr,
   input  logic [XLEN-1:0]   d,
   output logic [XLEN-1:0]   q
);

   logic [XLEN-1:0] mem [WORDS];
   logic [XLEN-1:0] merged;

   always_comb begin
      merged = mem[adr];
      for (int b = 0; b < XLEN/8; b++) begin
         if (we && be[b]) merged[b*8 +: 8] = d[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[adr] <= merged;
         q <= merged;
      end
   end

endmodule

// File: rtl/biu_ram_responder.sv
// rtl/biu_ram_responder.sv - single-transfer BIU responder backed by internal RAM
//
// Purpose : accepts BIU address phases, performs the RAM access at accept and
//           returns in-order ack/err plus read data LATENCY cycles later, with
//           at most DEPTH transfers outstanding.
// Ports   : rst_ni/clk_i          - async active-low reset, clock
//           biu_stb_i/_stb_ack_o  - request strobe / accepted this cycle
//           biu_adri_i/_adro_o    - request address / last accepted address
//           biu_size_i/_type_i    - transfer size / burst type (SINGLE only)
//           biu_lock_i/_prot_i    - ignored
//           biu_we_i/_d_i/_d_ack_o- write, write data, write data consumed
//           biu_q_o/_ack_o/_err_o - read data, completed OK, completed with error
module biu_ram_responder
   import biu_constants_pkg::*;
#(
   parameter int               XLEN      = 32,
   parameter int               ALEN      = XLEN,
   parameter int               LATENCY   = 2,
   parameter int               DEPTH     = 2,
   parameter int               MEM_BYTES = 4096,
   parameter logic [ALEN-1:0]  BASE      = '0
) (
   input  logic            rst_ni,
   input  logic            clk_i,
   input  logic            biu_stb_i,
   output logic            biu_stb_ack_o,
   input  logic [ALEN-1:0] biu_adri_i,
   output logic [ALEN-1:0] biu_adro_o,
   input  biu_size_t       biu_size_i,
   input  biu_type_t       biu_type_i,
   input  logic            biu_lock_i,
   input  logic            biu_we_i,
   input  biu_prot_t       biu_prot_i,
   input  logic [XLEN-1:0] biu_d_i,
   output logic [XLEN-1:0] biu_q_o,
   output logic            biu_d_ack_o,
   output logic            biu_ack_o,
   output logic            biu_err_o
);

   localparam int SW    = $clog2(XLEN/8);
   localparam int WORDS = MEM_BYTES / (XLEN/8);
   localparam int IW    = $clog2(WORDS);
   localparam int OW    = $clog2(DEPTH+1);

   logic [LATENCY-1:0] pv, pe, pw;
   logic [OW-1:0]      outstanding;
   logic               retire, accept;
   logic               mis_err, size_err, type_err, range_err, req_err;
   logic [ALEN-1:0]    off;
   logic [2:0]         lane;
   logic [XLEN/8-1:0]  be;
   logic [XLEN-1:0]    ram_q, rsp_data;
   logic               unused_ok;

   assign unused_ok = ^{biu_lock_i, biu_prot_i};

   assign retire        = pv[LATENCY-1];
   assign accept        = biu_stb_i & ((outstanding < OW'(DEPTH)) | retire);
   assign biu_stb_ack_o = accept;
   assign biu_d_ack_o   = accept & biu_we_i;

   // BASE is aligned to MEM_BYTES, so the offset alone decides range and index
   assign off  = biu_adri_i - BASE;
   assign lane = {(XLEN == 64) ? biu_adri_i[2] : 1'b0, biu_adri_i[1:0]};
   assign be   = (XLEN/8)'(biu_be(biu_size_i, lane));

   always_comb begin
      mis_err  = 1'b0;
      size_err = 1'b0;
      case (biu_size_i)
         BYTE   : mis_err = 1'b0;
         HWORD  : mis_err = biu_adri_i[0];
         WORD   : mis_err = |biu_adri_i[1:0];
         DWORD  : begin
            mis_err  = |biu_adri_i[2:0];
            size_err = (XLEN == 32);
         end
         default: size_err = 1'b1;
      endcase
   end

   assign type_err  = (biu_type_i != SINGLE);
   assign range_err = ({1'b0, off} >= (ALEN+1)'(MEM_BYTES));
   assign req_err   = mis_err | size_err | type_err | range_err;

   biu_ram_array #(
      .XLEN  (XLEN),
      .WORDS (WORDS),
      .IW    (IW)
   ) u_ram (
      .clk (clk_i),
      .en  (accept & ~req_err),
      .we  (biu_we_i),
      .be  (be),
      .adr (off[SW +: IW]),
      .d   (biu_d_i),
      .q   (ram_q)
   );

   // Control pipeline: stage 0 loads on accept, shifts every cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pv          <= '0;
         pe          <= '0;
         pw          <= '0;
         outstanding <= '0;
         biu_adro_o  <= '0;
      end else begin
         for (int i = LATENCY-1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pw[i] <= pw[i-1];
         end
         pv[0] <= accept;
         pe[0] <= req_err;
         pw[0] <= biu_we_i;

         case ({accept, retire})
            2'b10  : outstanding <= outstanding + 1'b1;
            2'b01  : outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         if (accept) biu_adro_o <= biu_adri_i;
      end
   end

   // RAM output lands one cycle after accept, so data starts at stage 1
   generate
      if (LATENCY > 1) begin : g_dpipe
         logic [XLEN-1:0] pd [1:LATENCY-1];
         always_ff @(posedge clk_i) begin
            pd[1] <= ram_q;
            for (int i = 2; i < LATENCY; i++) pd[i] <= pd[i-1];
         end
         assign rsp_data = pd[LATENCY-1];
      end else begin : g_direct
         assign rsp_data = ram_q;
      end
   endgenerate

   assign biu_ack_o = pv[LATENCY-1] & ~pe[LATENCY-1];
   assign biu_err_o = pv[LATENCY-1] &  pe[LATENCY-1];
   assign biu_q_o   = (biu_ack_o & ~pw[LATENCY-1]) ? rsp_data : '0;

endmodule

// File: tb/tb_biu_ram_responder.sv
// tb/tb_biu_ram_responder.sv - scoreboard bench for biu_ram_responder
module tb_biu_ram_responder;
   import biu_constants_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        stb = 1'b0;
   logic [31:0] adr = '0;
   biu_size_t   size = WORD;
   biu_type_t   typ = SINGLE;
   logic        we = 1'b0;
   logic [31:0] d = '0;
   logic        lock = 1'b0;
   biu_prot_t   prot = '0;

   logic [2:0]  stb_ack, d_ack, ack, err;
   logic [31:0] q_a, q_b, q_c, adro_a, adro_b, adro_c;

   // u_a: LATENCY=2 DEPTH=2, u_b: LATENCY=3 DEPTH=3, u_c: LATENCY=3 DEPTH=1
   biu_ram_responder #(.LATENCY(2), .DEPTH(2)) u_a (
      .rst_ni(rst_n), .clk_i(clk), .biu_stb_i(stb), .biu_stb_ack_o(stb_ack[0]),
      .biu_adri_i(adr), .biu_adro_o(adro_a), .biu_size_i(size), .biu_type_i(typ),
      .biu_lock_i(lock), .biu_we_i(we), .biu_prot_i(prot), .biu_d_i(d),
      .biu_q_o(q_a), .biu_d_ack_o(d_ack[0]), .biu_ack_o(ack[0]), .biu_err_o(err[0]));
   biu_ram_responder #(.LATENCY(3), .DEPTH(3)) u_b (
      .rst_ni(rst_n), .clk_i(clk), .biu_stb_i(stb), .biu_stb_ack_o(stb_ack[1]),
      .biu_adri_i(adr), .biu_adro_o(adro_b), .biu_size_i(size), .biu_type_i(typ),
      .biu_lock_i(lock), .biu_we_i(we), .biu_prot_i(prot), .biu_d_i(d),
      .biu_q_o(q_b), .biu_d_ack_o(d_ack[1]), .biu_ack_o(ack[1]), .biu_err_o(err[1]));
   biu_ram_responder #(.LATENCY(3), .DEPTH(1)) u_c (
      .rst_ni(rst_n), .clk_i(clk), .biu_stb_i(stb), .biu_stb_ack_o(stb_ack[2]),
      .biu_adri_i(adr), .biu_adro_o(adro_c), .biu_size_i(size), .biu_type_i(typ),
      .biu_lock_i(lock), .biu_we_i(we), .biu_prot_i(prot), .biu_d_i(d),
      .biu_q_o(q_c), .biu_d_ack_o(d_ack[2]), .biu_ack_o(ack[2]), .biu_err_o(err[2]));

   int sel = 0;
   int lat [3] = '{2, 3, 3};
   logic        m_stb_ack, m_d_ack, m_ack, m_err;
   logic [31:0] m_q, m_adro;

   always_comb begin
      m_stb_ack = stb_ack[sel];
      m_d_ack   = d_ack[sel];
      m_ack     = ack[sel];
      m_err     = err[sel];
      m_q       = (sel == 0) ? q_a : (sel == 1) ? q_b : q_c;
      m_adro    = (sel == 0) ? adro_a : (sel == 1) ? adro_b : adro_c;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      int          due;
      bit          err;
      logic [31:0] q;
   } exp_t;

   exp_t sb [$];
   int   acc [$];

   logic [7:0] mem_m [0:4095];

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      int b;
      b = int'(a & 32'hffc);
      return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
   endfunction

   task automatic wr_model(input biu_size_t sz, input logic [31:0] a, input logic [31:0] data);
      int n;
      int ad;
      n = (sz == BYTE) ? 1 : (sz == HWORD) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
         ad = int'(a) + i;
         mem_m[ad] = data[8*(ad % 4) +: 8];
      end
   endtask

   // Response monitor: every due entry must appear exactly in its cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check_val("resp_ack", m_ack, !e.err);
         check_val("resp_err", m_err, e.err);
         check_val("resp_q", m_q, e.q);
      end else if (m_ack || m_err) begin
         check_val("spurious_resp", {m_ack, m_err}, 2'b00);
      end
   end

   // Call just after a rising edge; returns after accept (+ adro check)
   task automatic req(input logic w, input biu_size_t sz, input logic [31:0] a,
                      input logic [31:0] data, input bit e_err, input bit chk_adro,
                      output int waits);
      exp_t e;
      stb = 1'b1; we = w; size = sz; adr = a; d = data; waits = 0;
      @(negedge clk);
      while (!m_stb_ack && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      if (!m_stb_ack) begin
         check_val("accept_timeout", 0, 1);
         return;
      end
      check_val("d_ack", m_d_ack, w);
      e.due = cyc + lat[sel];
      e.err = e_err;
      e.q   = (w || e_err) ? 32'h0 : rd_model(a);
      if (w && !e_err) wr_model(sz, a, data);
      sb.push_back(e);
      acc.push_back(cyc);
      if (chk_adro) begin
         @(posedge clk); #1;
         check_val("adro", m_adro, a);
      end
   endtask

   task automatic drain();
      stb = 1'b0; we = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      if (sb.size() != 0) check_val("drain_timeout", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      stb = 1'b0; we = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      check_val("watchdog", 0, 1);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      int w;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_stb_ack", m_stb_ack, 0);
      check_val("rst_d_ack", m_d_ack, 0);
      check_val("rst_ack_err", {m_ack, m_err}, 2'b00);
      check_val("rst_q", m_q, 0);
      check_val("rst_adro", m_adro, 0);
      check_val("rst_outstanding", u_a.outstanding, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Word write/read, byte merge, error cases (LATENCY=2)
      sel = 0;
      req(1'b1, WORD, 32'h10, 32'hdeadbeef, 1'b0, 1'b1, w);
      req(1'b0, WORD, 32'h10, 32'h0, 1'b0, 1'b1, w);
      req(1'b1, BYTE, 32'h11, 32'h0000aa00, 1'b0, 1'b1, w);
      req(1'b0, WORD, 32'h10, 32'h0, 1'b0, 1'b1, w);
      req(1'b0, WORD, 32'h12, 32'h0, 1'b1, 1'b1, w);
      req(1'b0, HWORD, 32'h13, 32'h0, 1'b1, 1'b1, w);
      req(1'b0, WORD, 32'h1000, 32'h0, 1'b1, 1'b1, w);
      req(1'b1, DWORD, 32'h10, 32'h12345678, 1'b1, 1'b1, w);
      req(1'b0, WORD, 32'h10, 32'h0, 1'b0, 1'b1, w);
      typ = INCR;
      req(1'b0, WORD, 32'h10, 32'h0, 1'b1, 1'b1, w);
      typ = SINGLE;
      req(1'b1, WORD, 32'hffc, 32'hcafef00d, 1'b0, 1'b1, w);
      req(1'b1, HWORD, 32'hffe, 32'h5a5a0000, 1'b0, 1'b1, w);
      req(1'b0, WORD, 32'hffc, 32'h0, 1'b0, 1'b1, w);
      drain();

      // Full throughput with DEPTH >= LATENCY
      do_reset();
      sel = 1;
      for (int i = 0; i < 8; i++)
         req(1'b1, WORD, 32'h100 + 32'(4*i), 32'h01020304 * (i + 1), 1'b0, 1'b1, w);
      acc.delete();
      for (int i = 0; i < 8; i++)
         req(1'b0, WORD, 32'h100 + 32'(4*i), 32'h0, 1'b0, 1'b1, w);
      for (int i = 1; i < acc.size(); i++)
         check_val("b2b_accept_gap", acc[i] - acc[i-1], 1);
      drain();

      // DEPTH=1: accept only when the previous response retires
      do_reset();
      sel = 2;
      acc.delete();
      req(1'b1, WORD, 32'h200, 32'h11223344, 1'b0, 1'b1, w);
      req(1'b1, WORD, 32'h204, 32'h55667788, 1'b0, 1'b1, w);
      req(1'b0, WORD, 32'h200, 32'h0, 1'b0, 1'b1, w);
      req(1'b0, WORD, 32'h204, 32'h0, 1'b0, 1'b1, w);
      for (int i = 1; i < acc.size(); i++)
         check_val("d1_accept_gap", acc[i] - acc[i-1], 3);
      drain();

      // Reset with two responses pending
      do_reset();
      sel = 0;
      req(1'b0, WORD, 32'h10, 32'h0, 1'b0, 1'b1, w);
      req(1'b0, WORD, 32'h10, 32'h0, 1'b0, 1'b0, w);
      rst_n = 1'b0;
      stb = 1'b0;
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_val("midrst_ack_err", {m_ack, m_err}, 2'b00);
      check_val("midrst_outstanding", u_a.outstanding, 0);
      repeat (4) @(posedge clk);
      #1;
      req(1'b0, WORD, 32'h10, 32'h0, 1'b0, 1'b1, w);
      check_val("post_rst_accept_wait", w, 0);
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
